// File: rtl/batch_accumulator.sv
// Element-wise accumulator over RUNS framed batches, streamed out as one framed batch.
// Optional BATCH_ACCUMULATOR_MEAN_EN: output the sum divided by RUNS (power of two) instead of the full sum.
module batch_accumulator #(
  parameter int BATCH_SIZE = 2048,
  parameter int RUNS       = 3,
  parameter int DATA_WIDTH = 14
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         sink_sop,
  input  logic                                         sink_eop,
  input  logic                                         sink_valid,
  input  logic signed [DATA_WIDTH-1:0]                 sink_data,
  output logic                                         source_sop,
  output logic                                         source_eop,
  output logic                                         source_valid,
  input  logic                                         source_ready,
`ifdef BATCH_ACCUMULATOR_MEAN_EN
  output logic signed [DATA_WIDTH-1:0]                 source_data,
`else
  output logic signed [DATA_WIDTH+$clog2(RUNS)-1:0]    source_data,
`endif
  output logic                                         frame_error,
  output logic                                         sink_dropped,
  output logic                                         done
);

  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(RUNS);
  localparam int IDX_W     = $clog2(BATCH_SIZE);
  localparam int RUN_W     = $clog2(RUNS);
`ifdef BATCH_ACCUMULATOR_MEAN_EN
  localparam int OUT_W     = DATA_WIDTH;
`else
  localparam int OUT_W     = ACC_WIDTH;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BATCH_SIZE - 1);
  localparam logic [RUN_W-1:0] LAST_RUN = RUN_W'(RUNS - 1);

  if (BATCH_SIZE < 2) begin : g_bs_chk
    $error("batch_accumulator: BATCH_SIZE must be at least 2");
  end
  if (RUNS < 2) begin : g_runs_chk
    $error("batch_accumulator: RUNS must be at least 2");
  end
`ifdef BATCH_ACCUMULATOR_MEAN_EN
  if ((1 << $clog2(RUNS)) != RUNS) begin : g_pow2_chk
    $error("batch_accumulator: RUNS must be a power of two when the mean output is enabled");
  end

  // Arithmetic shift rounds toward -inf; the quotient always fits DATA_WIDTH.
  function automatic logic signed [OUT_W-1:0] out_of(input logic signed [ACC_WIDTH-1:0] s);
    return OUT_W'(s >>> RUN_W);
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] out_of(input logic signed [ACC_WIDTH-1:0] s);
    return s;
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, COLLECT, DUMP} state_t;

  state_t                        state, state_next;
  logic [IDX_W-1:0]              idx, idx_next;
  logic [IDX_W-1:0]              rd, rd_next;
  logic [RUN_W-1:0]              run, run_next;
  logic signed [ACC_WIDTH-1:0]   acc [BATCH_SIZE];
  logic signed [ACC_WIDTH-1:0]   ext;
  logic                          wr_en;
  logic [IDX_W-1:0]              wr_addr;
  logic signed [ACC_WIDTH-1:0]   wr_data;
  logic                          beat_ok;
  logic                          ferr_set, drop_set;
  logic                          sv_next, sop_next, eop_next, done_next;
  logic signed [OUT_W-1:0]       data_next;

  assign ext     = {{(ACC_WIDTH-DATA_WIDTH){sink_data[DATA_WIDTH-1]}}, sink_data};
  assign beat_ok = (sink_sop == (idx == '0)) && (sink_eop == (idx == LAST_IDX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    run_next   = run;
    rd_next    = rd;
    wr_en      = 1'b0;
    wr_addr    = idx;
    wr_data    = ext;
    ferr_set   = 1'b0;
    drop_set   = 1'b0;
    sv_next    = source_valid;
    sop_next   = source_sop;
    eop_next   = source_eop;
    data_next  = source_data;
    done_next  = 1'b0;
    case (state)
      // IDLE is COLLECT with idx 0 and run 0, so both share the framing logic.
      IDLE, COLLECT: begin
        if (sink_valid) begin
          if (beat_ok) begin
            wr_en   = 1'b1;
            wr_data = (run == '0) ? ext : acc[idx] + ext;
            if (idx == LAST_IDX) begin
              idx_next = '0;
              if (run == LAST_RUN) begin
                state_next = DUMP;
                rd_next    = '0;
              end else begin
                run_next   = run + RUN_W'(1);
                state_next = COLLECT;
              end
            end else begin
              idx_next   = idx + IDX_W'(1);
              state_next = COLLECT;
            end
          end else begin
            ferr_set = 1'b1;
            run_next = '0;
            if (sink_sop) begin
              wr_en      = 1'b1;
              wr_addr    = '0;
              idx_next   = IDX_W'(1);
              state_next = COLLECT;
            end else begin
              idx_next   = '0;
              state_next = IDLE;
            end
          end
        end
      end
      DUMP: begin
        drop_set = sink_valid;
        if (source_valid && source_ready && source_eop) begin
          sv_next    = 1'b0;
          sop_next   = 1'b0;
          eop_next   = 1'b0;
          done_next  = 1'b1;
          run_next   = '0;
          state_next = IDLE;
        end else if (!source_valid || source_ready) begin
          sv_next   = 1'b1;
          sop_next  = (rd == '0);
          eop_next  = (rd == LAST_IDX);
          data_next = out_of(acc[rd]);
          if (rd != LAST_IDX) rd_next = rd + IDX_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) acc[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      rd           <= '0;
      run          <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_data  <= '0;
      frame_error  <= 1'b0;
      sink_dropped <= 1'b0;
      done         <= 1'b0;
    end else begin
      idx          <= idx_next;
      rd           <= rd_next;
      run          <= run_next;
      source_valid <= sv_next;
      source_sop   <= sop_next;
      source_eop   <= eop_next;
      source_data  <= data_next;
      frame_error  <= frame_error | ferr_set;
      sink_dropped <= sink_dropped | drop_set;
      done         <= done_next;
    end
  end

endmodule

// File: doc/batch_accumulator.md
Name: batch_accumulator

Overview:
- Receiving end of the sop/eop/valid/data batch stream: consumes RUNS consecutive framed batches of BATCH_SIZE signed entries, e.g. per-bin FFT power.
- Accumulates the batches element-wise into on-chip memory, then streams the per-index sums out as one framed batch under a valid/ready handshake.
- Sits downstream of the FFT. Feeds the integration/readout logic.

Parameters:
- BATCH_SIZE, 2048: entries per batch; must be ≥ 2.
- RUNS, 3: batches summed per output batch; must be ≥ 2.
- DATA_WIDTH, 14: bits per input entry, signed two's complement.
- ACC_WIDTH (localparam): DATA_WIDTH + $clog2(RUNS); accumulator and source width.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high; clears all state.
- sink_sop  in  1  first entry of input batch.
- sink_eop  in  1  last entry of input batch.
- sink_valid  in  1  input beat present; there is no backpressure on the sink side.
- sink_data  in  DATA_WIDTH  signed input entry.
- source_sop  out  1  first output entry.
- source_eop  out  1  last output entry.
- source_valid  out  1  output beat present.
- source_ready  in  1  downstream accepts the beat when source_valid && source_ready.
- source_data  out  ACC_WIDTH (MEAN_EN: DATA_WIDTH)  signed accumulated entry.
- frame_error  out  1  sticky; set on framing violation.
- sink_dropped  out  1  sticky; set when a sink beat arrives during DUMP.
- done  out  1  one-cycle pulse after the last output beat is accepted.

Behaviour:
- Reset (asynchronous, active-high), all of these are 0: source_* outputs, frame_error, sink_dropped, done, run counter, index counter. State becomes IDLE. Memory contents are don't-care.
- Storage: acc[0:BATCH_SIZE-1] of ACC_WIDTH bits; asynchronous read, synchronous write.
- Sink data is sign-extended to ACC_WIDTH before any arithmetic.
- States: IDLE, COLLECT, DUMP.
- IDLE:
  - sink_valid && sink_sop: accept beat as idx 0 of the current run; go to COLLECT.
  - sink_valid && !sink_sop: beat is dropped and frame_error is set.
- COLLECT, each beat with sink_valid:
  - run 0: acc[idx] <= data.
  - runs > 0: acc[idx] <= acc[idx] + data. The read-modify-write completes in one cycle, so back-to-back beats are allowed.
- Framing checks, applied to every accepted beat:
  - sop must equal (idx == 0).
  - eop must equal (idx == BATCH_SIZE-1).
- Violation handling:
  - set frame_error, abort all runs (run <= 0), go to IDLE.
  - If the violating beat carries sop, it is instead taken as idx 0 of a fresh run 0 and the state stays COLLECT.
  - Otherwise the violating beat is not written.
- Gaps (sink_valid low) inside or between batches are legal and do not advance idx.
- End of batch: beat idx BATCH_SIZE-1 with eop resets idx to 0.
  - If run < RUNS-1: run increments; wait in COLLECT for the next sop (a non-sop beat there is a violation).
  - If run == RUNS-1: go to DUMP.
- DUMP:
  - The output register loads acc[rd] whenever !source_valid || source_ready.
  - First source_valid appears 1 cycle after entering DUMP.
  - source_sop accompanies rd == 0; source_eop accompanies rd == BATCH_SIZE-1.
  - Outputs hold stable while source_valid && !source_ready.
  - After the eop beat is accepted: source_valid <= 0, done pulses, run <= 0, go to IDLE.
  - Any sink_valid during DUMP is discarded and sets sink_dropped; the memory is untouched.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: BATCH_ACCUMULATOR_MEAN_EN.
- Defined: source_data is DATA_WIDTH wide and equals sum >>> $clog2(RUNS) (arithmetic shift, round toward -inf). RUNS must be a power of two; elaboration fails otherwise via a generate-time $error.
- Undefined: source_data is ACC_WIDTH wide and carries the full sum. No RUNS restriction beyond ≥ 2.

Test Plan:
All scenarios use BATCH_SIZE=4, RUNS=3, DATA_WIDTH=8, ACC_WIDTH=10, feature off unless stated.
1. Clean accumulation: 3 contiguous batches with run r, idx i data = 10r+i, source_ready=1 -> output 30,33,36,39; sop on 30, eop on 39; done pulses once; frame_error=0.
2. Signed extremes: 3 batches of all -128 -> output four × -384 (10-bit 0x280); then 3 batches of all 127 -> four × 381.
3. Backpressure: scenario 1 data, source_ready pattern 1,0,0,1,0,1,1 -> accepted sequence exactly 30,33,36,39; data/sop/eop stable on every stalled cycle.
4. Framing error: eop on idx 2 of run 1 -> frame_error=1, IDLE, nothing output. Then 3 clean batches of scenario 1 -> 30,33,36,39. Also sop at idx 2 of run 0 -> restart as idx 0; the following 3-batch set is correct.
5. Dropped beats: sink_valid pulses during DUMP with source_ready=0 -> sink_dropped=1, output still 30,33,36,39.
6. Reset mid-DUMP after 2 accepted beats -> all outputs 0 in the same cycle (asynchronous); next clean set outputs 30,33,36,39.
   - Rerun with BATCH_ACCUMULATOR_MEAN_EN and RUNS=4, inputs 1,2,3,4 per run at idx 0 -> mean 2 (sum 10 >>> 2).
